mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-memory access stage between the ex_mem register and the mem_wb register.
- Takes the ALU result (address), the store data and the memory control bits from ex_mem, and runs a variable-latency request/ack transaction with the data memory.
- Stalls the upstream pipeline while the access is in flight and returns readData for mem_wb.
- Supports word and signed-byte accesses, flags misaligned word accesses, and flags memory timeouts.

Parameters:
- TIMEOUT, 16: maximum number of WAIT cycles without mem_ack before a bus error is raised. Must be ≥1.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ex_mem holds a real instruction (not a bubble).
- in_addr  in  32  byte address (ex_mem result).
- in_wdata  in  32  store data.
- in_memRead  in  1  load.
- in_memWrite  in  1  store.
- in_byte  in  1  1 = byte access, 0 = word access.
- mem_req  out  1  request to data memory, registered.
- mem_we  out  1  write request, registered.
- mem_addr  out  32  word-aligned address ({in_addr[31:2],2'b00}), registered.
- mem_wdata  out  32  store data, registered.
- mem_be  out  4  byte enables, registered.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read word.
- readData  out  32  load result for mem_wb.
- stall  out  1  freeze pc/if_id/id_ex/ex_mem.
- wb_clear  out  1  drive mem_wb clear (insert bubble).
- done  out  1  one-cycle pulse: memory access completed.
- align_err  out  1  one-cycle pulse: misaligned word access.
- bus_err  out  1  one-cycle pulse (with done): memory timeout.

Behaviour:
- Reset:
  - State goes to IDLE.
  - mem_req, mem_we, done, align_err and bus_err go to 0.
  - mem_addr, mem_wdata, mem_be and readData go to 0; counter goes to 0.
  - Reset mid-transaction drops mem_req at the same edge. A later mem_ack is ignored.
- States: IDLE, WAIT, RESP.
- Definitions:
  - acc = in_valid & (in_memRead | in_memWrite).
  - mis = acc & ~in_byte & (in_addr[1:0] != 0).
  - If in_memRead and in_memWrite are both 1, treat the op as a store.
- IDLE, acc & ~mis:
  - Combinational outputs: stall=1, wb_clear=1.
  - At the next edge: latch the request, set mem_req=1, go to WAIT, counter=0.
  - Word access: mem_be=4'b1111, mem_wdata=in_wdata.
  - Byte access: mem_be=one-hot(in_addr[1:0]), little-endian (addr 0 → bit 0), mem_wdata={4{in_wdata[7:0]}}.
- IDLE, mis:
  - No request is issued.
  - Combinational outputs: align_err=1, wb_clear=1 (squash), stall=0.
- IDLE, ~acc:
  - Pass-through: stall=0, wb_clear=~in_valid.
  - readData is don't-care; mem_wb uses result.
- WAIT:
  - stall=1, wb_clear=1, mem_req held with constant address, data and enables.
  - If mem_ack=1: capture readData, set mem_req=0, go to RESP.
  - Else if counter==TIMEOUT-1: set mem_req=0, readData=0, set a bus_err flag, go to RESP.
  - Else: counter increments.
- readData formation (load):
  - Word: readData=mem_rdata.
  - Byte: readData = sign-extension of the selected lane. Lane = mem_rdata[8*a+7:8*a], with a = latched addr[1:0].
  - Store: readData=0.
- RESP (exactly one cycle):
  - stall=0, wb_clear=0, done=1, bus_err=flag.
  - mem_wb captures readData at the edge ending RESP; ex_mem advances at the same edge.
  - Next state is IDLE. No back-to-back acceptance from RESP.
  - Latency: one IDLE cycle + N WAIT cycles + one RESP cycle, so stall lasts N+1 cycles when ack arrives in the N-th WAIT cycle (N≥1).
- mem_ack outside WAIT is ignored.
- in_* changes while stall=1 are a protocol violation. Inputs are re-sampled only in IDLE.
- Timeout counter saturates; it never wraps within a transaction.
- A bus_err load is still written back as 0. Trap handling is outside this block.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/WAIT/RESP),
  - byte-enable constants (BE_WORD=4'b1111),
  - a function for lane select with sign-extension,
  - a function for address-to-byte-enable mapping.
- One natural sub-module: mem_load_align. This is combinational: latched addr[1:0] + in_byte + mem_rdata → readData. It is reused later by the writeback stage for halfword support.

Test Plan:
- Word load, addr 0x100, ack in the 3rd WAIT cycle with rdata 0xDEADBEEF. Required:
  - mem_req=1 for 3 cycles, mem_addr=0x100, mem_be=4'hF.
  - stall=1 for 4 cycles, then RESP with done=1 and readData=0xDEADBEEF.
- Byte load, addr 0x103, rdata 0x80123456. Required: readData=0xFFFFFF80. Same byte load at addr 0x101: readData=0x00000034.
- Byte store, addr 0x102, wdata 0x000000AB. Required: mem_we=1, mem_be=4'b0100, mem_wdata=0xABABABAB, readData=0.
- Word load, addr 0x102. Required: align_err=1 for one cycle, mem_req never asserted, stall=0, wb_clear=1.
- No ack, TIMEOUT=16. Required: mem_req=1 for exactly 16 cycles, then done=1, bus_err=1, readData=0. A mem_ack arriving one cycle later is ignored.
- reset=1 in the 2nd WAIT cycle. Required: next cycle mem_req=0 and state IDLE. A following non-memory instruction passes with stall=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory access stage.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // Pick byte lane a of a little-endian word and sign-extend it to 32 bits.
  function automatic logic [31:0] lane_sext(input logic [31:0] word, input logic [1:0] a);
    logic [7:0] b;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {{24{b[7]}}, b};
  endfunction

  // Byte enables for an access: all lanes for a word, one-hot lane for a byte.
  function automatic logic [3:0] addr_to_be(input logic [1:0] a, input logic is_byte);
    if (!is_byte) return BE_WORD;
    return BE_BYTE0 << a;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: turns the raw memory word into the architectural load value.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic        is_byte_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  // Word loads pass through; byte loads select and sign-extend one lane.
  always_comb begin
    rdata_o = rdata_i;
    if (is_byte_i) rdata_o = lane_sext(rdata_i, addr_lo_i);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: issues one request/ack transaction per memory
// instruction, stalls upstream while it is in flight, and returns load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_memRead,
  input  logic        in_memWrite,
  input  logic        in_byte,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] readData,
  output logic        stall,
  output logic        wb_clear,
  output logic        done,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              byte_q, byte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              berr_q, berr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_val;
  logic              acc, mis;

  assign acc = in_valid & (in_memRead | in_memWrite);
  assign mis = acc & ~in_byte & (in_addr[1:0] != 2'b00);

  mem_load_align u_align (
    .addr_lo_i (addr_lo_q),
    .is_byte_i (byte_q),
    .rdata_i   (mem_rdata),
    .rdata_o   (load_val)
  );

  // Next-state, request datapath and pipeline-control outputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    addr_lo_d = addr_lo_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    berr_d    = berr_q;
    rdata_d   = rdata_q;
    stall     = 1'b0;
    wb_clear  = 1'b0;
    done      = 1'b0;
    align_err = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      IDLE: begin
        wb_clear = ~in_valid;
        if (mis) begin
          align_err = 1'b1;
          wb_clear  = 1'b1;
        end else if (acc) begin
          stall     = 1'b1;
          wb_clear  = 1'b1;
          state_d   = WAIT;
          req_d     = 1'b1;
          // Both read and write set resolves to a store.
          we_d      = in_memWrite;
          addr_d    = {in_addr[31:2], 2'b00};
          be_d      = addr_to_be(in_addr[1:0], in_byte);
          wdata_d   = in_byte ? {4{in_wdata[7:0]}} : in_wdata;
          addr_lo_d = in_addr[1:0];
          byte_d    = in_byte;
          cnt_d     = '0;
          berr_d    = 1'b0;
        end
      end
      WAIT: begin
        stall    = 1'b1;
        wb_clear = 1'b1;
        if (mem_ack) begin
          rdata_d = we_q ? '0 : load_val;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        done    = 1'b1;
        bus_err = berr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      addr_lo_q <= '0;
      byte_q    <= 1'b0;
      cnt_q     <= '0;
      berr_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      addr_lo_q <= addr_lo_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      berr_q    <= berr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign readData  = rdata_q;

endmodule
